loopback_frame_checker: RTL and testbench

- Self-checking TX→RX loopback comparator for the 802.11a PHY chain. Replaces the ad-hoc compare loop in the bench with a synthesizable block that can also run on-board.
- Captures each transmitted frame beat into a reference FIFO and compares it, in order, against beats arriving from the receiver after an arbitrary pipeline latency.
- Reports beat errors, bit errors, the first error index, FIFO overflow/underflow, timeout, and a final pass/fail.
- Generalised to DATA_W bits per beat and a configurable latency depth.

---
 rtl/loopback_frame_checker_pkg.sv | 38 +++
 rtl/loopback_ref_fifo.sv | 55 +++++
 rtl/loopback_frame_checker.sv | 164 ++++++++++++++++
 tb/tb_loopback_frame_checker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loopback_frame_checker_pkg.sv
// Shared definitions for the TX->RX loopback frame checker: FSM encoding and
// width-generic arithmetic helpers (operands zero-extended to CALC_W bits).
package loopback_frame_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest beat / counter the helpers can handle.
  localparam int unsigned CALC_W = 64;

  function automatic logic [CALC_W-1:0] sat_add(
    input logic [CALC_W-1:0] a,
    input logic [CALC_W-1:0] b,
    input int unsigned       w
  );
    logic [CALC_W-1:0] lim;
    logic [CALC_W:0]   sum;
    lim = (w >= CALC_W) ? '1 : ((CALC_W'(1) << w) - CALC_W'(1));
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) begin
      return lim;
    end
    return sum[CALC_W-1:0];
  endfunction

  function automatic logic [CALC_W-1:0] popcount(input logic [CALC_W-1:0] v);
    logic [CALC_W-1:0] n;
    n = '0;
    for (int i = 0; i < CALC_W; i++) begin
      n = n + CALC_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/loopback_ref_fifo.sv
// Reference FIFO holding transmitted beats until their looped-back copy arrives.
// Caller guarantees Push only when !Full or Pop, and Pop only when !Empty.
module loopback_ref_fifo #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Clear,
  input  logic              Push,
  input  logic              Pop,
  input  logic [DATA_W-1:0] Wdata,
  output logic [DATA_W-1:0] Rdata,
  output logic              Full,
  output logic              Empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (Clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (Push) wr_ptr <= wr_ptr + AW'(1);
      if (Pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({Push, Pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Push) mem[wr_ptr] <= Wdata;
  end

  assign Rdata = mem[rd_ptr];
  assign Full  = (count == CNT_W'(DEPTH));
  assign Empty = (count == '0);

endmodule

// File: rtl/loopback_frame_checker.sv
// Compares looped-back RX beats in order against the TX beats of a frame and
// reports error counts, first error index, FIFO faults, timeout and pass/fail.
module loopback_frame_checker
  import loopback_frame_checker_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int DEPTH   = 32,
  parameter int LEN_W   = 16,
  parameter int ERR_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [LEN_W-1:0]  Frame_len,
  input  logic [DATA_W-1:0] Tx_data,
  input  logic              Tx_valid,
  input  logic [DATA_W-1:0] Rx_data,
  input  logic              Rx_valid,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic              Timed_out,
  output logic              Overflow,
  output logic              Underflow,
  output logic [ERR_W-1:0]  Beat_err,
  output logic [ERR_W-1:0]  Bit_err,
  output logic [LEN_W-1:0]  First_err_idx,
  output state_e            Dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  // Tx_valid / Rx_valid are qualify-only strobes with no ready: in RUN every
  // valid beat is taken on the rising edge it is presented.

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, tx_cnt_q, rx_cnt_q, first_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [ERR_W-1:0]  beat_err_q, bit_err_q, beat_err_d, bit_err_d;
  logic              pass_q, timed_out_q, ovf_q, unf_q, ovf_d, unf_d, pass_d;

  logic              run, start_ok, tx_acc, rx_acc, bypass, no_ref, mismatch;
  logic              tx_store, drop, frame_end, timeout_hit;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata, ref_data, diff;
  logic [CALC_W-1:0] bit_inc, beat_sum, bit_sum;

  loopback_ref_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ref_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clear   (start_ok),
    .Push    (fifo_push),
    .Pop     (fifo_pop),
    .Wdata   (Tx_data),
    .Rdata   (fifo_rdata),
    .Full    (fifo_full),
    .Empty   (fifo_empty)
  );

  assign run      = (state_q == ST_RUN);
  assign start_ok = (state_q == ST_IDLE) && Start;
  assign tx_acc   = run && Tx_valid && (tx_cnt_q < len_q);
  assign rx_acc   = run && Rx_valid;

  // An empty FIFO with a same-cycle TX beat compares directly against Tx_data.
  assign bypass   = rx_acc && fifo_empty && tx_acc;
  assign no_ref   = rx_acc && fifo_empty && !tx_acc;
  assign ref_data = fifo_empty ? Tx_data : fifo_rdata;
  assign fifo_pop = rx_acc && !fifo_empty;
  assign tx_store = tx_acc && !bypass;
  assign fifo_push = tx_store && (!fifo_full || fifo_pop);
  assign drop     = tx_store && fifo_full && !fifo_pop;

  assign diff     = Rx_data ^ ref_data;
  assign mismatch = rx_acc && (no_ref || (diff != '0));
  assign bit_inc  = no_ref ? CALC_W'(DATA_W) : popcount(CALC_W'(diff));
  assign beat_sum = sat_add(CALC_W'(beat_err_q), CALC_W'(1), ERR_W);
  assign bit_sum  = sat_add(CALC_W'(bit_err_q), bit_inc, ERR_W);

  assign beat_err_d = mismatch ? beat_sum[ERR_W-1:0] : beat_err_q;
  assign bit_err_d  = mismatch ? bit_sum[ERR_W-1:0]  : bit_err_q;
  assign ovf_d      = ovf_q | drop;
  assign unf_d      = unf_q | no_ref;
  assign pass_d     = (beat_err_d == '0) && !ovf_d && !unf_d;

  assign frame_end   = rx_acc && ((rx_cnt_q + LEN_W'(1)) == len_q);
  assign timeout_hit = run && !rx_acc && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Start) state_d = (Frame_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (frame_end || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q == ST_RUN);
    Done = (state_q == ST_DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      len_q       <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      to_cnt_q    <= '0;
      beat_err_q  <= '0;
      bit_err_q   <= '0;
      first_q     <= '1;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (start_ok) begin
      len_q       <= Frame_len;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      to_cnt_q    <= '0;
      beat_err_q  <= '0;
      bit_err_q   <= '0;
      first_q     <= '1;
      pass_q      <= (Frame_len == '0);
      timed_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (run) begin
      tx_cnt_q   <= tx_cnt_q + LEN_W'(tx_acc);
      rx_cnt_q   <= rx_cnt_q + LEN_W'(rx_acc);
      to_cnt_q   <= rx_acc ? '0 : to_cnt_q + TO_W'(1);
      beat_err_q <= beat_err_d;
      bit_err_q  <= bit_err_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      if (mismatch && (first_q == '1)) first_q <= rx_cnt_q;
      // Verdict is settled on the edge that leaves RUN, including the final beat.
      if (frame_end || timeout_hit) begin
        pass_q      <= timeout_hit ? 1'b0 : pass_d;
        timed_out_q <= timeout_hit;
      end
    end
  end

  assign Pass          = pass_q;
  assign Timed_out     = timed_out_q;
  assign Overflow      = ovf_q;
  assign Underflow     = unf_q;
  assign Beat_err      = beat_err_q;
  assign Bit_err       = bit_err_q;
  assign First_err_idx = first_q;
  assign Dbg_state     = state_q;

endmodule

// File: tb/tb_loopback_frame_checker.sv
// Bench for loopback_frame_checker: queue-based reference model checked every
// cycle, plus literal expectations for the directed loopback scenarios.
module tb_loopback_frame_checker;

  localparam int DATA_W  = 4;
  localparam int DEPTH   = 32;
  localparam int LEN_W   = 16;
  localparam int ERR_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int SAT     = (1 << ERR_W) - 1;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Start = 1'b0;
  logic [LEN_W-1:0]  Frame_len = '0;
  logic [DATA_W-1:0] Tx_data = '0;
  logic              Tx_valid = 1'b0;
  logic [DATA_W-1:0] Rx_data = '0;
  logic              Rx_valid = 1'b0;
  logic              Busy, Done, Pass, Timed_out, Overflow, Underflow;
  logic [ERR_W-1:0]  Beat_err, Bit_err;
  logic [LEN_W-1:0]  First_err_idx;
  loopback_frame_checker_pkg::state_e dbg_state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [DATA_W-1:0] tx_mem [512];
  logic [DATA_W-1:0] err_mask [512];

  loopback_frame_checker #(
    .DATA_W (DATA_W), .DEPTH (DEPTH), .LEN_W (LEN_W), .ERR_W (ERR_W), .TIMEOUT (TIMEOUT)
  ) u_dut (
    .Clk (Clk), .Reset_n (Reset_n), .Start (Start), .Frame_len (Frame_len),
    .Tx_data (Tx_data), .Tx_valid (Tx_valid), .Rx_data (Rx_data), .Rx_valid (Rx_valid),
    .Busy (Busy), .Done (Done), .Pass (Pass), .Timed_out (Timed_out),
    .Overflow (Overflow), .Underflow (Underflow), .Beat_err (Beat_err),
    .Bit_err (Bit_err), .First_err_idx (First_err_idx), .Dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int m_running = 0, m_done = 0, m_pass = 0, m_to = 0, m_ovf = 0, m_unf = 0;
  int m_beat = 0, m_bit = 0, m_first = -1;
  int m_len = 0, m_tx = 0, m_rx = 0, m_idle = 0;
  logic [DATA_W-1:0] ref_q [$];

  task automatic model_clear();
    m_pass = 0; m_to = 0; m_ovf = 0; m_unf = 0;
    m_beat = 0; m_bit = 0; m_first = -1;
    m_tx = 0; m_rx = 0; m_idle = 0;
    ref_q.delete();
  endtask

  task automatic model_err(input int idx, input int bits);
    m_beat = (m_beat + 1 > SAT) ? SAT : m_beat + 1;
    m_bit  = (m_bit + bits > SAT) ? SAT : m_bit + bits;
    if (m_first < 0) m_first = idx;
  endtask

  always @(posedge Clk or negedge Reset_n) begin : model
    bit tx_acc, bypass, have;
    logic [DATA_W-1:0] r;
    if (!Reset_n) begin
      model_clear();
      m_running = 0; m_done = 0; m_len = 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_running != 0) begin
      tx_acc = Tx_valid && (m_tx < m_len);
      bypass = 1'b0;
      if (Rx_valid) begin
        have = 1'b1;
        r = '0;
        if (ref_q.size() > 0) r = ref_q.pop_front();
        else if (tx_acc) begin r = Tx_data; bypass = 1'b1; end
        else begin have = 1'b0; m_unf = 1; end
        if (!have) model_err(m_rx, DATA_W);
        else if (r != Rx_data) model_err(m_rx, $countones(r ^ Rx_data));
        m_rx++;
        m_idle = 0;
      end else begin
        m_idle++;
      end
      if (tx_acc) begin
        m_tx++;
        if (!bypass) begin
          if (ref_q.size() < DEPTH) ref_q.push_back(Tx_data);
          else m_ovf = 1;
        end
      end
      if (m_rx == m_len || m_idle == TIMEOUT) begin
        m_to      = (m_rx == m_len) ? 0 : 1;
        m_pass    = (m_to == 0 && m_beat == 0 && m_ovf == 0 && m_unf == 0) ? 1 : 0;
        m_running = 0;
        m_done    = 1;
      end
    end else if (Start) begin
      model_clear();
      if (Frame_len == 0) begin
        m_done = 1; m_pass = 1;
      end else begin
        m_running = 1; m_len = int'(Frame_len);
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    check("busy",      Busy,      m_running);
    check("done",      Done,      m_done);
    check("pass",      Pass,      m_pass);
    check("timed_out", Timed_out, m_to);
    check("overflow",  Overflow,  m_ovf);
    check("underflow", Underflow, m_unf);
    check("beat_err",  Beat_err,  m_beat);
    check("bit_err",   Bit_err,   m_bit);
    check("first_idx", First_err_idx, (m_first < 0) ? 65535 : m_first);
    if (Done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  // Entered and left at #1 after a rising edge.
  task automatic drive_frame(input int len, input int delay, input int ncyc);
    Start = 1'b1;
    Frame_len = LEN_W'(len);
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      Tx_valid = (c < len);
      Tx_data  = (c < len) ? tx_mem[c] : '0;
      Rx_valid = (c >= delay) && (c - delay < len);
      Rx_data  = Rx_valid ? (tx_mem[c - delay] ^ err_mask[c - delay]) : '0;
      @(posedge Clk); #1;
    end
    Tx_valid = 1'b0;
    Rx_valid = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!Done && k < 200) begin
      @(posedge Clk); #1;
      k++;
    end
    check("done_seen", Done, 1);
  endtask

  task automatic fill(input int len, input int maxv);
    for (int i = 0; i < 512; i++) begin
      tx_mem[i]   = (i < len) ? DATA_W'($urandom_range(0, maxv)) : '0;
      err_mask[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int k, d0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", Busy, 0);
    check("rst_pass", Pass, 0);
    check("rst_first", First_err_idx, 16'hFFFF);
    check("rst_beat", Beat_err, 0);
    Reset_n = 1'b1;
    step();

    // 1: clean 264-beat frame, 20-cycle loop latency
    fill(264, 1);
    d0 = done_cnt;
    drive_frame(264, 20, 284);
    wait_done(k);
    check("t1_done_lat", k, 0);
    check("t1_pass", Pass, 1);
    check("t1_beat", Beat_err, 0);
    check("t1_first", First_err_idx, 16'hFFFF);
    step();
    check("t1_done_once", done_cnt - d0, 1);

    // 2: beats 5 and 100 flipped
    err_mask[5] = 4'b0001;
    err_mask[100] = 4'b0001;
    drive_frame(264, 20, 284);
    wait_done(k);
    check("t2_beat", Beat_err, 2);
    check("t2_bit", Bit_err, 2);
    check("t2_first", First_err_idx, 5);
    check("t2_pass", Pass, 0);
    step();

    // 3: 4-bit beats, beat 3 corrupted by 1011
    fill(8, 15);
    err_mask[3] = 4'b1011;
    drive_frame(8, 3, 11);
    wait_done(k);
    check("t3_beat", Beat_err, 1);
    check("t3_bit", Bit_err, 3);
    check("t3_first", First_err_idx, 3);
    step();

    // 4a: latency beyond FIFO depth
    fill(64, 15);
    drive_frame(64, 40, 104);
    wait_done(k);
    check("t4_ovf", Overflow, 1);
    check("t4_pass", Pass, 0);
    step();

    // 4b: zero-latency loopback uses the bypass compare
    drive_frame(64, 0, 64);
    wait_done(k);
    check("t4b_unf", Underflow, 0);
    check("t4b_pass", Pass, 1);
    check("t4b_beat", Beat_err, 0);
    step();

    // 5: no RX at all -> timeout
    drive_frame(10, 0, 0);
    wait_done(k);
    check("t5_done_cycle", k, 64);
    check("t5_timed_out", Timed_out, 1);
    check("t5_pass", Pass, 0);
    step();

    // zero-length frame completes immediately with a pass
    drive_frame(0, 0, 0);
    check("t0_done", Done, 1);
    check("t0_pass", Pass, 1);
    step();

    // 6: reset after 50 RX beats, then a clean frame
    fill(100, 15);
    d0 = done_cnt;
    drive_frame(100, 5, 55);
    check("t6_busy_pre", Busy, 1);
    Reset_n = 1'b0;
    #1;
    check("t6_busy", Busy, 0);
    check("t6_done", Done, 0);
    check("t6_first", First_err_idx, 16'hFFFF);
    check("t6_beat", Beat_err, 0);
    repeat (3) step();
    check("t6_no_done", done_cnt - d0, 0);
    Reset_n = 1'b1;
    step();
    fill(30, 15);
    drive_frame(30, 7, 37);
    wait_done(k);
    check("t6_clean_pass", Pass, 1);
    check("t6_clean_beat", Beat_err, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
